// File: rtl/ram_controller_ex_lfsr8_checker.sv
// Read-side LFSR pattern checker: regenerates the per-byte-lane 8-bit LFSR stream
// and compares it with controller read data, keeping error statistics and pass/fail.
module ram_controller_ex_lfsr8_checker #(
   parameter int SEED      = 32,
   parameter int LANES     = 1,
   parameter int NUM_WORDS = 16,
   parameter int CNT_W     = 16,
   parameter int ERR_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic                 start,
   input  logic                 rd_valid,
   input  logic [8*LANES-1:0]   rd_data,
   input  logic                 resync,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 fail,
   output logic [ERR_W-1:0]     err_count,
   output logic [LANES-1:0]     lane_err,
   output logic [CNT_W-1:0]     first_err_index,
   output logic [8*LANES-1:0]   first_err_expected,
   output logic [8*LANES-1:0]   first_err_actual,
   output logic                 unexpected
);

   typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_DONE} state_t;

   function automatic logic [7:0] lfsr_step(input logic [7:0] q);
      return {q[6], q[5], q[4], q[3] ^ q[7], q[2] ^ q[7], q[1] ^ q[7], q[0], q[7]};
   endfunction

   function automatic logic [8*LANES-1:0] seed_word();
      logic [8*LANES-1:0] w;
      w = '0;
      for (int i = 0; i < LANES; i++) w[8*i +: 8] = 8'((SEED + i) % 256);
      return w;
   endfunction

   localparam logic [8*LANES-1:0] SEEDS    = seed_word();
   localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(NUM_WORDS - 1);

   state_t               state_q, state_d;
   logic                 busy_q, busy_d, done_q, done_d;
   logic [8*LANES-1:0]   lfsr_q, lfsr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ERR_W-1:0]     err_q, err_d;
   logic                 fail_q, fail_d, unexp_q, unexp_d;
   logic [LANES-1:0]     lane_err_q, lane_err_d;
   logic [CNT_W-1:0]     fidx_q, fidx_d;
   logic [8*LANES-1:0]   fexp_q, fexp_d, fact_q, fact_d;
   logic [LANES-1:0]     lane_mis;
   logic [8*LANES-1:0]   lfsr_next, lfsr_resync;

   always_comb begin
      lane_mis    = '0;
      lfsr_next   = '0;
      lfsr_resync = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_mis[i]          = rd_data[8*i +: 8] != lfsr_q[8*i +: 8];
         lfsr_next[8*i +: 8]   = lfsr_step(lfsr_q[8*i +: 8]);
         lfsr_resync[8*i +: 8] = lfsr_step(rd_data[8*i +: 8]);
      end
   end

   // Priority: enable low, then start, then word acceptance.
   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      fail_d     = fail_q;
      unexp_d    = unexp_q;
      lane_err_d = lane_err_q;
      fidx_d     = fidx_q;
      fexp_d     = fexp_q;
      fact_d     = fact_q;
      if (!enable) begin
         state_d = ST_IDLE;
         lfsr_d  = SEEDS;
         cnt_d   = '0;
      end else if (start) begin
         state_d    = ST_CHECK;
         lfsr_d     = SEEDS;
         cnt_d      = '0;
         err_d      = '0;
         fail_d     = 1'b0;
         unexp_d    = 1'b0;
         lane_err_d = '0;
         fidx_d     = '0;
         fexp_d     = '0;
         fact_d     = '0;
      end else if (rd_valid) begin
         if (state_q != ST_CHECK) begin
            unexp_d = 1'b1;
         end else begin
            if (resync) begin
               lfsr_d = lfsr_resync;
            end else begin
               lfsr_d = lfsr_next;
               if (|lane_mis) begin
                  // fail is cleared only by start, so !fail_q marks the first miss
                  if (!fail_q) begin
                     fidx_d = cnt_q;
                     fexp_d = lfsr_q;
                     fact_d = rd_data;
                  end
                  fail_d     = 1'b1;
                  lane_err_d = lane_err_q | lane_mis;
                  if (err_q != '1) err_d = err_q + ERR_W'(1);
               end
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IDX) state_d = ST_DONE;
         end
      end
      busy_d = state_d == ST_CHECK;
      done_d = state_d == ST_DONE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         lfsr_q     <= SEEDS;
         cnt_q      <= '0;
         err_q      <= '0;
         fail_q     <= 1'b0;
         unexp_q    <= 1'b0;
         lane_err_q <= '0;
         fidx_q     <= '0;
         fexp_q     <= '0;
         fact_q     <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         lfsr_q     <= lfsr_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         fail_q     <= fail_d;
         unexp_q    <= unexp_d;
         lane_err_q <= lane_err_d;
         fidx_q     <= fidx_d;
         fexp_q     <= fexp_d;
         fact_q     <= fact_d;
      end
   end

   assign busy               = busy_q;
   assign done               = done_q;
   assign pass               = done_q && (err_q == '0);
   assign fail               = fail_q;
   assign err_count          = err_q;
   assign lane_err           = lane_err_q;
   assign first_err_index    = fidx_q;
   assign first_err_expected = fexp_q;
   assign first_err_actual   = fact_q;
   assign unexpected         = unexp_q;

endmodule

// File: tb/tb_ram_controller_ex_lfsr8_checker.sv
// Bench for the LFSR read checker: directed scenarios plus random traffic,
// all outputs compared every cycle against a behavioural model.
module tb_ram_controller_ex_lfsr8_checker;
   localparam int LANES = 2, NW = 10, CW = 8, EW = 3, SEED = 32;
   localparam int DW = 8 * LANES;

   logic clk = 1'b0;
   logic reset_n, enable, start, rd_valid, resync;
   logic [DW-1:0] rd_data;
   logic busy, done, pass, fail, unexpected;
   logic [EW-1:0] err_count;
   logic [LANES-1:0] lane_err;
   logic [CW-1:0] first_err_index;
   logic [DW-1:0] first_err_expected, first_err_actual;

   ram_controller_ex_lfsr8_checker #(.SEED(SEED), .LANES(LANES), .NUM_WORDS(NW),
      .CNT_W(CW), .ERR_W(EW)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .start(start),
      .rd_valid(rd_valid), .rd_data(rd_data), .resync(resync),
      .busy(busy), .done(done), .pass(pass), .fail(fail), .err_count(err_count),
      .lane_err(lane_err), .first_err_index(first_err_index),
      .first_err_expected(first_err_expected), .first_err_actual(first_err_actual),
      .unexpected(unexpected));

   always #5 clk = ~clk;

   int errors = 0, checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Model: 0 idle, 1 check, 2 done
   int            m_st, m_cnt, m_err, m_fidx;
   bit            m_fail, m_unexp;
   logic [7:0]    m_lfsr[LANES];
   logic [LANES-1:0] m_lane;
   logic [DW-1:0] m_fexp, m_fact;

   function automatic logic [7:0] step(input logic [7:0] q);
      logic [7:0] s;
      s = q << 1;
      return s ^ (q[7] ? 8'h1D : 8'h00);
   endfunction

   function automatic logic [DW-1:0] expw();
      logic [DW-1:0] w;
      for (int i = 0; i < LANES; i++) w[8*i +: 8] = m_lfsr[i];
      return w;
   endfunction

   task automatic m_reload();
      for (int i = 0; i < LANES; i++) m_lfsr[i] = 8'(SEED + i);
      m_cnt = 0;
   endtask

   task automatic m_clear();
      m_err = 0; m_fail = 0; m_unexp = 0; m_lane = '0;
      m_fidx = 0; m_fexp = '0; m_fact = '0;
   endtask

   task automatic m_reset();
      m_st = 0; m_reload(); m_clear();
   endtask

   task automatic model(input bit en, input bit st, input bit v, input logic [DW-1:0] d, input bit rs);
      logic [DW-1:0] e;
      if (!en) begin
         m_st = 0; m_reload();
      end else if (st) begin
         m_clear(); m_reload(); m_st = 1;
      end else if (v) begin
         if (m_st != 1) m_unexp = 1;
         else begin
            e = expw();
            if (rs) begin
               for (int i = 0; i < LANES; i++) m_lfsr[i] = step(d[8*i +: 8]);
            end else begin
               if (d != e) begin
                  if (!m_fail) begin m_fidx = m_cnt; m_fexp = e; m_fact = d; end
                  m_fail = 1;
                  for (int i = 0; i < LANES; i++) if (d[8*i +: 8] != e[8*i +: 8]) m_lane[i] = 1'b1;
                  if (m_err < (1 << EW) - 1) m_err++;
               end
               for (int i = 0; i < LANES; i++) m_lfsr[i] = step(m_lfsr[i]);
            end
            if (m_cnt == NW - 1) m_st = 2;
            m_cnt++;
         end
      end
   endtask

   task automatic check_all();
      chk("busy", busy, m_st == 1);
      chk("done", done, m_st == 2);
      chk("pass", pass, m_st == 2 && m_err == 0);
      chk("fail", fail, m_fail);
      chk("err_count", err_count, m_err);
      chk("lane_err", lane_err, m_lane);
      chk("first_idx", first_err_index, m_fidx);
      chk("first_exp", first_err_expected, m_fexp);
      chk("first_act", first_err_actual, m_fact);
      chk("unexpected", unexpected, m_unexp);
   endtask

   task automatic cyc(input bit en, input bit st, input bit v, input logic [DW-1:0] d, input bit rs);
      enable = en; start = st; rd_valid = v; rd_data = d; resync = rs;
      @(posedge clk);
      model(en, st, v, d, rs);
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, '0, 0);
   endtask

   task automatic async_reset();
      reset_n = 1'b0;
      #2;
      m_reset();
      check_all();
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b1; enable = 0; start = 0; rd_valid = 0; rd_data = '0; resync = 0;
      #1 reset_n = 1'b0;
      m_reset();
      #1 check_all();
      @(posedge clk);
      #1 reset_n = 1'b1;

      // clean run: lane 0 stream 20,40,80,1D,3A,...
      cyc(1, 1, 0, '0, 0);
      for (int w = 0; w < NW; w++) cyc(1, 0, 1, expw(), 0);
      chk("t1_pass", pass, 1);
      chk("t1_w4", {first_err_index, err_count}, 0);

      // single-bit miss at word 2 on lane 0
      cyc(1, 1, 0, '0, 0);
      for (int w = 0; w < NW; w++) cyc(1, 0, 1, (w == 2) ? expw() ^ 16'h0001 : expw(), 0);
      chk("t2_idx", first_err_index, 2);
      chk("t2_exp", first_err_expected[7:0], 8'h80);
      chk("t2_act", first_err_actual[7:0], 8'h81);
      chk("t2_lane", lane_err, 2'b01);
      chk("t2_pass", pass, 0);

      // gaps between words; second miss at word 4 on lane 1
      cyc(1, 1, 0, '0, 0);
      for (int w = 0; w < NW; w++) begin
         cyc(1, 0, 1, (w == 2) ? expw() ^ 16'h0001 : (w == 4) ? expw() & 16'h00FF : expw(), 0);
         idle(3);
      end
      chk("t3_err", err_count, 2);
      chk("t3_idx", first_err_index, 2);
      chk("t3_lane", lane_err, 2'b11);

      // resync to 0x55: next words are step(55)=AA, step(AA)=49
      cyc(1, 1, 0, '0, 0);
      cyc(1, 0, 1, 16'h5555, 1);
      cyc(1, 0, 1, 16'hAAAA, 0);
      cyc(1, 0, 1, 16'h4949, 0);
      chk("t4_err", err_count, 0);
      chk("t4_busy", busy, 1);

      // mid-run reset, then a fresh run
      cyc(1, 1, 0, '0, 0);
      cyc(1, 0, 1, expw(), 0);
      cyc(1, 0, 1, expw() ^ 16'hFF00, 0);
      async_reset();
      chk("t5_busy", busy, 0);
      cyc(1, 1, 0, '0, 0);
      cyc(1, 0, 1, 16'h2120, 0);
      chk("t5_first", err_count, 0);

      // unexpected data while idle, cleared by start; enable drop holds stats
      cyc(0, 0, 0, '0, 0);
      cyc(1, 0, 1, 16'h2120, 0);
      chk("t6_unexp", unexpected, 1);
      cyc(1, 1, 1, 16'h0000, 0);
      chk("t6_clr", unexpected, 0);
      cyc(1, 0, 1, 16'h1234, 0);
      cyc(0, 0, 0, '0, 0);
      chk("t6_busy", busy, 0);
      chk("t6_hold", {fail, err_count}, {1'b1, 3'd1});

      // every word wrong: counter saturates at 7
      cyc(1, 1, 0, '0, 0);
      for (int w = 0; w < NW; w++) cyc(1, 0, 1, ~expw(), 0);
      chk("sat", err_count, 7);
      chk("sat_done", {done, pass, fail}, 3'b101);

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         logic [DW-1:0] d;
         d = expw();
         if ($urandom_range(0, 5) == 0) d = d ^ DW'($urandom);
         cyc($urandom_range(0, 15) != 0, $urandom_range(0, 24) == 0,
             $urandom_range(0, 1) == 1, d, $urandom_range(0, 11) == 0);
         if ($urandom_range(0, 299) == 0) async_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
